// File: rtl/bandit_ctrl_pkg.sv
// bandit_ctrl_pkg: shared game state codes, state width and state-class helpers
package bandit_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        WELCOME = 4'd0,
        GAME    = 4'd1,
        SCORE   = 4'd2,
        ERROR   = 4'd3,
        COIN    = 4'd4,
        PASS    = 4'd5,
        LOSE    = 4'd6
    } state_t;

    function automatic logic is_dwell(input state_t s);
        return s == PASS || s == LOSE || s == ERROR;
    endfunction

    function automatic logic is_legal(input logic [STATE_W-1:0] s);
        return s < 4'd7;
    endfunction

endpackage

// File: rtl/bandit_ctrl_hold_timer.sv
// hold_timer: dwell counter (clk, rst, clr, en in; tc high while enabled at HOLD_CYCLES-1)
module hold_timer #(
    parameter longint unsigned HOLD_CYCLES = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = en && cnt == CNT_W'(HOLD_CYCLES - 1);

endmodule

// File: rtl/bandit_ctrl.sv
// bandit_ctrl: game FSM (clk, rst, start/coin/score/pass/lose pulses in; cur_state, credits, state_chg_p, timeout_p out)
module bandit_ctrl
    import bandit_ctrl_pkg::*;
#(
    parameter longint unsigned HOLD_CYCLES = 200_000_000,
    parameter int CREDIT_MAX = 9,
    parameter int COST = 1,
    localparam int CREDIT_W = $clog2(CREDIT_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_p,
    input  logic                coin_p,
    input  logic                score_p,
    input  logic                pass_p,
    input  logic                lose_p,
    output logic [STATE_W-1:0]  cur_state,
    output logic [CREDIT_W-1:0] credits,
    output logic                state_chg_p,
    output logic                timeout_p
);

    state_t              state, nxt;
    logic [CREDIT_W-1:0] crd_n;
    logic                act, to, tc, clr, dwell, afford;

    assign dwell  = is_dwell(state);
    assign afford = credits >= CREDIT_W'(COST);

    always_comb begin
        nxt   = is_legal(state) ? state : WELCOME;
        crd_n = credits;
        act   = 1'b1;
        to    = 1'b0;
        if (start_p) begin
            nxt   = afford ? GAME : ERROR;
            crd_n = afford ? credits - CREDIT_W'(COST) : credits;
        end else if (coin_p) begin
            nxt   = COIN;
            crd_n = credits == CREDIT_W'(CREDIT_MAX) ? credits : credits + CREDIT_W'(1);
        end else if (score_p)
            nxt = SCORE;
        else if (pass_p && state == GAME)
            nxt = PASS;
        else if (lose_p && state == GAME)
            nxt = LOSE;
        else begin
            act = 1'b0;
            nxt = tc ? WELCOME : nxt;
            to  = tc;
        end
    end

    // Any acting event restarts the dwell, including re-entry of the same dwell state.
    assign clr = act || !is_dwell(nxt);

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (dwell),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WELCOME;
            cur_state   <= '0;
            credits     <= '0;
            state_chg_p <= 1'b0;
            timeout_p   <= 1'b0;
        end else begin
            state       <= nxt;
            cur_state   <= state;
            state_chg_p <= state != cur_state;
            credits     <= crd_n;
            timeout_p   <= to;
        end
    end

endmodule

// File: tb/tb_bandit_ctrl.sv
// tb_bandit_ctrl: directed self-checking bench for bandit_ctrl (HOLD_CYCLES=8, CREDIT_MAX=3, COST=1)
module tb_bandit_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_p = 1'b0, coin_p = 1'b0, score_p = 1'b0, pass_p = 1'b0, lose_p = 1'b0;
    logic [3:0] cur_state;
    logic [1:0] credits;
    logic       state_chg_p, timeout_p;
    int         total = 0;
    int         bad = 0;

    bandit_ctrl #(.HOLD_CYCLES(8), .CREDIT_MAX(3), .COST(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_p     (start_p),
        .coin_p      (coin_p),
        .score_p     (score_p),
        .pass_p      (pass_p),
        .lose_p      (lose_p),
        .cur_state   (cur_state),
        .credits     (credits),
        .state_chg_p (state_chg_p),
        .timeout_p   (timeout_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        {start_p, coin_p, score_p, pass_p, lose_p} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_cur", cur_state, 0);
        chk("rst_cred", credits, 0);
        chk("rst_chg", state_chg_p, 0);
        chk("rst_to", timeout_p, 0);
        do_reset();

        // start with no credits -> ERROR, timeout after 8 cycles
        start_p = 1; tick();
        chk("err_cur_lat", cur_state, 0);
        tick();
        chk("err_cur", cur_state, 3);
        chk("err_chg", state_chg_p, 1);
        for (int i = 3; i <= 8; i++) begin
            tick();
            chk("err_to_early", timeout_p, 0);
        end
        tick();
        chk("err_to", timeout_p, 1);
        chk("err_to_cur", cur_state, 3);
        tick();
        chk("wel_cur", cur_state, 0);
        chk("wel_chg", state_chg_p, 1);
        chk("wel_to_clr", timeout_p, 0);

        // five coins, saturating at 3
        begin
            logic [1:0] ec [5] = '{1, 2, 3, 3, 3};
            logic       eg [5] = '{0, 1, 0, 0, 0};
            for (int i = 0; i < 5; i++) begin
                coin_p = 1; tick();
                chk("coin_cred", credits, ec[i]);
                chk("coin_chg", state_chg_p, eg[i]);
            end
        end
        tick();
        chk("coin_cur", cur_state, 4);
        chk("coin_chg_idle", state_chg_p, 0);

        // credits=2, start, pass, score, pass ignored in SCORE
        do_reset();
        coin_p = 1; tick();
        coin_p = 1; tick();
        chk("g_cred2", credits, 2);
        start_p = 1; tick();
        chk("g_cred1", credits, 1);
        pass_p = 1; tick();
        chk("g_cur_game", cur_state, 1);
        tick();
        chk("g_cur_pass", cur_state, 5);
        score_p = 1; tick();
        tick();
        chk("g_cur_score", cur_state, 2);
        pass_p = 1; tick();
        chk("g_pass_ign_cur", cur_state, 2);
        chk("g_pass_ign_chg", state_chg_p, 0);
        tick();
        chk("g_pass_ign_cur2", cur_state, 2);
        chk("g_pass_ign_cred", credits, 1);

        // start and coin together with no credits -> ERROR, then re-entry restarts dwell
        do_reset();
        start_p = 1; coin_p = 1; tick();
        chk("sc_cred", credits, 0);
        tick();
        chk("sc_cur", cur_state, 3);
        tick(); tick();
        start_p = 1; tick();
        chk("re_cred", credits, 0);
        for (int i = 6; i <= 12; i++) begin
            tick();
            chk("re_to_early", timeout_p, 0);
        end
        tick();
        chk("re_to", timeout_p, 1);

        // coin on the LOSE timeout cycle wins
        do_reset();
        coin_p = 1; tick();
        start_p = 1; tick();
        lose_p = 1; tick();
        for (int i = 0; i < 7; i++) tick();
        chk("lose_cur", cur_state, 6);
        coin_p = 1; tick();
        chk("lose_to", timeout_p, 0);
        chk("lose_cred", credits, 1);
        tick();
        chk("lose_cur_coin", cur_state, 4);
        chk("lose_to2", timeout_p, 0);

        // async reset at PASS dwell count 5
        do_reset();
        coin_p = 1; tick();
        start_p = 1; tick();
        pass_p = 1; tick();
        for (int i = 0; i < 5; i++) tick();
        chk("pr_cur", cur_state, 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_cur", cur_state, 0);
        chk("ar_cred", credits, 0);
        chk("ar_chg", state_chg_p, 0);
        chk("ar_to", timeout_p, 0);
        tick();
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                seen = seen | timeout_p | (cur_state != 4'd0);
            end
            chk("ar_quiet", seen, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
